// File: rtl/ram_pkg.sv
// Shared types for the byte-enabled single-port SRAM: FSM state encoding and
// the per-byte even-parity helper.
package ram_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  // Even parity bit: makes the total number of ones in {byte, bit} even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: READ_LATENCY register stages carrying {valid, data, err}.
// Data is only loaded alongside a valid, so the last stage holds its value between reads.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1]                 err_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      err_pipe[1] <= in_vld & in_err;
      if (in_vld) dat_pipe[1] <= in_data;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        err_pipe[s] <= err_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[READ_LATENCY];
  assign out_err  = err_pipe[READ_LATENCY];
  assign out_data = dat_pipe[READ_LATENCY];

endmodule

// File: rtl/ram_sp_be_init.sv
// Single-port SRAM with byte enables, registered read latency and hardware zero-init.
// Define PARITY_EN to store one even-parity bit per byte lane with error injection.
module ram_sp_be_init
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    par_inj,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    ready,
  output logic                    parity_err
);

  localparam int                    NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt, init_cnt_nxt;
  logic                    init_we;
  logic                    in_range, wr_en, rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_err;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_we      = 1'b0;
    case (state)
      S_INIT: begin
        init_we      = rst_n;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == LAST) begin
          state_nxt    = S_IDLE;
          init_cnt_nxt = '0;
        end
      end
      S_IDLE:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  assign ready    = (state == S_IDLE);
  assign in_range = ({1'b0, address} < DEPTH_W);
  assign wr_en    = cs & we & ready & in_range;
  assign rd_en    = cs & ~we & ready;
  // Out-of-range reads still complete, returning zero.
  assign rd_word  = in_range ? mem[address] : '0;

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[address][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

`ifdef PARITY_EN
  logic [NB-1:0] par_mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (init_we) begin
      par_mem[init_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) par_mem[address][i] <= byte_par(wdata[8*i +: 8]) ^ par_inj;
    end
  end

  always_comb begin
    rd_err = 1'b0;
    if (in_range)
      for (int i = 0; i < NB; i++)
        if (par_mem[address][i] != byte_par(mem[address][8*i +: 8])) rd_err = 1'b1;
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign rd_err         = 1'b0;
`endif

  ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (rd_en),
    .in_data (rd_word),
    .in_err  (rd_err),
    .out_vld (rvalid),
    .out_data(rdata),
    .out_err (parity_err)
  );

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Bench for ram_sp_be_init (RAM_DEPTH=200, READ_LATENCY=2) against a word-array
// reference model with an expected-read queue keyed by return cycle.
module tb_ram_sp_be_init;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int LAT   = 2;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        pe;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst_n, cs, we, par_inj;
  logic [3:0]    be;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid, ready, parity_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          init_left = DEPTH;
  logic [31:0] mem_m [256];
  logic [3:0]  pbad_m [256];
  rd_t         exp_q[$];
  rd_t         obs_q[$];

  ram_sp_be_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be), .address(address),
    .wdata(wdata), .par_inj(par_inj), .rdata(rdata), .rvalid(rvalid),
    .ready(ready), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // One clock: advance the reference model with the pre-edge inputs, then record outputs.
  task automatic tick();
    rd_t  e;
    logic acc;
    int   a;
    acc  = rst_n && (init_left == 0) && cs;
    a    = int'(address);
    e.d  = '0;
    e.pe = 1'b0;
    e.cyc = 0;
    if (acc && !we && a < DEPTH) begin
      e.d = mem_m[a];
`ifdef PARITY_EN
      e.pe = |pbad_m[a];
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      init_left = DEPTH;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin mem_m[i] = '0; pbad_m[i] = '0; end
    end else if (init_left > 0) begin
      init_left--;
    end else if (acc && we && a < DEPTH) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) begin mem_m[a][8*i +: 8] = wdata[8*i +: 8]; pbad_m[a][i] = par_inj; end
    end
    #1;
    cyc++;
    if (acc && !we) begin e.cyc = cyc + LAT - 1; exp_q.push_back(e); end
    if (rvalid === 1'b1) obs_q.push_back(rd_t'{cyc, rdata, parity_err});
  endtask

  task automatic set_idle();
    cs = 0; we = 0; be = '0; address = '0; wdata = '0; par_inj = 0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b, input logic inj);
    cs = 1; we = 1; be = b; address = a; wdata = d; par_inj = inj;
  endtask

  task automatic set_rd(input logic [AW-1:0] a);
    cs = 1; we = 0; be = 4'hF; address = a; wdata = $urandom; par_inj = 0;
  endtask

  task automatic drain();
    set_idle();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset();
    int cnt, t0;
    rst_n = 0;
    set_idle();
    repeat (3) tick();
    checks += 4;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    rst_n = 1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < DEPTH + 8) begin
      set_rd(AW'($urandom_range(0, 255)));
      cnt++;
      tick();
    end
    checks += 2;
    if (cnt != DEPTH) begin errors++; $display("FAIL init_len: got %0d want %0d", cnt, DEPTH); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL init_rvalid: got %0d reads want 0", obs_q.size()); end
    t0 = cyc;
    set_rd(8'h7F);
    tick();
    drain();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL init_read_count: got %0d want 1", obs_q.size());
    end else begin
      checks += 2;
      if (obs_q[0].d !== 32'h0) begin errors++; $display("FAIL init_read_data: got %h want 0", obs_q[0].d); end
      if (obs_q[0].cyc != t0 + LAT) begin errors++; $display("FAIL init_read_lat: got %0d want %0d", obs_q[0].cyc, t0 + LAT); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_byte_lanes();
    set_wr(5, 32'hAABBCCDD, 4'hF, 0); tick();
    set_wr(5, 32'h11223344, 4'b0101, 0); tick();
    set_wr(6, 32'hDEADBEEF, 4'h0, 0); tick();
    set_rd(5); tick();
    set_rd(6); tick();
    drain();
    checks += 2;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL be_count: got %0d want 2", obs_q.size());
    end else begin
      checks += 2;
      if (obs_q[0].d !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge: got %h want AA22CC44", obs_q[0].d); end
      if (obs_q[1].d !== 32'h0) begin errors++; $display("FAIL be_zero_noop: got %h want 0", obs_q[1].d); end
    end
    if (rdata !== 32'h0 || rvalid !== 1'b0) begin errors++; $display("FAIL rdata_hold: got %h/%b want 0/0", rdata, rvalid); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL be_model_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pipelined();
    int t0;
    logic [31:0] want [3];
    want[0] = 32'h10; want[1] = 32'h20; want[2] = 32'h30;
    for (int i = 0; i < 3; i++) begin set_wr(AW'(i + 1), want[i], 4'hF, 0); tick(); end
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin set_rd(AW'(i + 1)); tick(); end
    drain();
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL pipe_count: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].d !== want[i] || obs_q[i].cyc != t0 + LAT + i) begin
          errors++;
          $display("FAIL pipe_%0d: got %h at %0d want %h at %0d", i, obs_q[i].d, obs_q[i].cyc, want[i], t0 + LAT + i);
        end
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_out_of_range();
    set_wr(190, 32'h5A5A1234, 4'hF, 0); tick();
    set_wr(210, 32'hFFFFFFFF, 4'hF, 0); tick();
    set_rd(210); tick();
    set_rd(190); tick();
    drain();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL oor_count: got %0d want 2", obs_q.size());
    end else begin
      checks += 2;
      if (obs_q[0].d !== 32'h0 || obs_q[0].pe !== 1'b0) begin errors++; $display("FAIL oor_read: got %h pe%b want 0 pe0", obs_q[0].d, obs_q[0].pe); end
      if (obs_q[1].d !== 32'h5A5A1234) begin errors++; $display("FAIL oor_neighbour: got %h want 5A5A1234", obs_q[1].d); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    logic want_pe;
`ifdef PARITY_EN
    want_pe = 1'b1;
`else
    want_pe = 1'b0;
`endif
    set_wr(9, 32'h0, 4'hF, 0); tick();
    set_wr(9, 32'h01020304, 4'b0010, 1); tick();
    set_rd(9); tick();
    set_wr(9, 32'h01020304, 4'b0010, 0); tick();
    set_rd(9); tick();
    drain();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL par_count: got %0d want 2", obs_q.size());
    end else begin
      checks += 2;
      if (obs_q[0].d !== 32'h00000300 || obs_q[0].pe !== want_pe) begin
        errors++; $display("FAIL par_inject: got %h pe%b want 00000300 pe%b", obs_q[0].d, obs_q[0].pe, want_pe);
      end
      if (obs_q[1].d !== 32'h00000300 || obs_q[1].pe !== 1'b0) begin
        errors++; $display("FAIL par_clean: got %h pe%b want 00000300 pe0", obs_q[1].d, obs_q[1].pe);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int cnt;
    set_rd(5); tick();
    rst_n = 0; set_idle(); tick();
    rst_n = 1;
    checks += 2;
    if (rvalid !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL mid_drop: got rvalid %b reads %0d want 0/0", rvalid, obs_q.size()); end
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready); end
    cnt = 0;
    while (ready !== 1'b1 && cnt < DEPTH + 8) begin tick(); cnt++; end
    checks++;
    if (cnt != DEPTH) begin errors++; $display("FAIL mid_init_len: got %0d want %0d", cnt, DEPTH); end
    set_rd(5); tick();
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].d !== 32'h0) begin
      errors++; $display("FAIL mid_rezero: got %0d reads first %h want 1 read of 0", obs_q.size(), obs_q.size() ? obs_q[0].d : 32'hx);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) set_idle();
      else if ($urandom_range(0, 1) == 0)
        set_wr(AW'($urandom_range(0, 215)), $urandom, 4'($urandom), 1'($urandom));
      else set_rd(AW'($urandom_range(0, 215)));
      tick();
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].d !== exp_q[i].d || obs_q[i].pe !== exp_q[i].pe) begin
        errors++;
        $display("FAIL rand_rd_%0d: got cyc%0d %h pe%b want cyc%0d %h pe%b", i,
                 obs_q[i].cyc, obs_q[i].d, obs_q[i].pe, exp_q[i].cyc, exp_q[i].d, exp_q[i].pe);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    test_reset();
    test_byte_lanes();
    test_pipelined();
    test_out_of_range();
    test_parity();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
